// File: rtl/alu_lbist_engine_pkg.sv
// Shared definitions for the ALU logic-BIST engine:
// register map, FSM encoding and the op-index to ALU-op table.
package alu_lbist_pkg;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_GOLDEN   = 8'h08;
  localparam logic [7:0] REG_SIG      = 8'h0C;
  localparam logic [7:0] REG_SEED     = 8'h10;
  localparam logic [7:0] REG_RUN_CNT  = 8'h14;
  localparam logic [7:0] REG_FAIL_CNT = 8'h18;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_XOR,
    ALU_SLL,
    ALU_SLT
  } alu_op_e;

  // The wrapper maps op_sel onto the real ALU operator through this table
  function automatic alu_op_e op_of(input logic [1:0] idx);
    alu_op_e op;
    unique case (idx)
      2'd0:    op = ALU_ADD;
      2'd1:    op = ALU_XOR;
      2'd2:    op = ALU_SLL;
      default: op = ALU_SLT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_lbist_engine_if.sv
// APB slave bus bundle for the ALU logic-BIST engine.
// Zero-wait-state peripheral; the engine is the slave side.
interface alu_lbist_engine_if;
  logic [31:0] paddr_i;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport master (
    output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/alu_lbist_engine_lfsr_misr.sv
// Galois shift register; with DATA_EN it folds a data word in
// every step (MISR), without it it is a free-running LFSR.
module lbist_lfsr_misr #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(32'h8020_0003),
  parameter bit               DATA_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] fb;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] nxt;

  assign fb  = state[WIDTH-1] ? POLY : '0;
  assign din = DATA_EN ? data : '0;
  assign nxt = {state[WIDTH-2:0], 1'b0} ^ fb ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/alu_lbist_engine.sv
// Runtime logic-BIST for the ALU: LFSR patterns per op, MISR
// compaction, golden compare and an APB register block.
module alu_lbist_engine
  import alu_lbist_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    NUM_OPS         = 4,
  parameter int                    PATTERNS_PER_OP = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY       =
    DATA_WIDTH'(32'h8020_0003),
  localparam int OW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  idle_i,
  output logic                  bist_active_o,
  output logic [DATA_WIDTH-1:0] pat_a_o,
  output logic [DATA_WIDTH-1:0] pat_b_o,
  output logic [OW-1:0]         op_sel_o,
  input  logic [DATA_WIDTH-1:0] dut_result_i,
  alu_lbist_engine_if.slave     apb,
  output logic                  error_irq_o
);

  localparam int PPO = PATTERNS_PER_OP;
  localparam int PW  = (PPO > 1) ? $clog2(PPO) : 1;
  localparam int HW  = DATA_WIDTH / 2;
  localparam logic [OW-1:0] OP_LAST  = OW'(NUM_OPS - 1);
  localparam logic [PW-1:0] PAT_LAST = PW'(PPO - 1);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  auto_q;
  logic                  auto_d;
  logic                  irq_en_q;
  logic                  done_q;
  logic                  fail_q;
  logic                  abort_q;
  logic [DATA_WIDTH-1:0] golden_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] sig_q;
  logic [15:0]           run_cnt_q;
  logic [15:0]           fail_cnt_q;
  logic [OW-1:0]         op_q;
  logic [PW-1:0]         pat_q;
  logic [DATA_WIDTH-1:0] lfsr;
  logic [DATA_WIDTH-1:0] misr;
  logic [DATA_WIDTH-1:0] lfsr_seed;

  logic       access;
  logic       wr;
  logic [7:0] addr;
  logic       wr_ctrl;
  logic       wr_stat;
  logic       run;
  logic       step;
  logic       enter_run;
  logic       last;
  logic       check;
  logic       abort;
  logic       mismatch;
  logic       busy;
  logic [31:0] rdata;
  logic        rerr;
  logic        unused_apb;

  assign access  = apb.psel_i & apb.penable_i;
  assign wr      = access & apb.pwrite_i;
  assign addr    = apb.paddr_i[7:0];
  assign wr_ctrl = wr & (addr == REG_CTRL);
  assign wr_stat = wr & (addr == REG_STATUS);
  assign auto_d  = wr_ctrl ? apb.pwdata_i[1] : auto_q;

  assign run       = state_q == ST_RUN;
  assign step      = run & idle_i;
  assign abort     = run & ~idle_i;
  assign check     = state_q == ST_CHECK;
  assign busy      = state_q != ST_IDLE;
  assign last      = step & (op_q == OP_LAST) & (pat_q == PAT_LAST);
  assign enter_run = (state_q == ST_ARMED) & (state_d == ST_RUN);
  assign mismatch  = misr != golden_q;

  // Zero seed would lock the LFSR at zero forever
  assign lfsr_seed = (seed_q == '0) ? DATA_WIDTH'(1) : seed_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((wr_ctrl & apb.pwdata_i[0]) | auto_q) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (wr_ctrl & ~apb.pwdata_i[1] & auto_q) state_d = ST_IDLE;
        else if (idle_i)                         state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!idle_i)   state_d = ST_ARMED;
        else if (last) state_d = ST_CHECK;
      end
      ST_CHECK: state_d = auto_d ? ST_ARMED : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (enter_run || last) begin
        op_q  <= '0;
        pat_q <= '0;
      end else if (step) begin
        if (pat_q == PAT_LAST) begin
          pat_q <= '0;
          op_q  <= op_q + 1'b1;
        end else begin
          pat_q <= pat_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      abort_q    <= 1'b0;
      golden_q   <= '0;
      seed_q     <= '0;
      sig_q      <= '0;
      run_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (wr_ctrl) begin
        auto_q   <= apb.pwdata_i[1];
        irq_en_q <= apb.pwdata_i[2];
      end
      if (wr & (addr == REG_GOLDEN)) golden_q <= apb.pwdata_i[DATA_WIDTH-1:0];
      if (wr & (addr == REG_SEED))   seed_q   <= apb.pwdata_i[DATA_WIDTH-1:0];
      // A status bit being set outranks a W1C in the same cycle
      done_q  <= check | (done_q & ~(wr_stat & apb.pwdata_i[1]));
      fail_q  <= (check & mismatch) |
                 (fail_q & ~(wr_stat & apb.pwdata_i[2]));
      abort_q <= abort | (abort_q & ~(wr_stat & apb.pwdata_i[3]));
      if (check) begin
        sig_q <= misr;
        if (run_cnt_q != 16'hFFFF) run_cnt_q <= run_cnt_q + 16'd1;
        if (mismatch && fail_cnt_q != 16'hFFFF) begin
          fail_cnt_q <= fail_cnt_q + 16'd1;
        end
      end
    end
  end

  lbist_lfsr_misr #(
    .WIDTH  (DATA_WIDTH),
    .POLY   (LFSR_POLY),
    .DATA_EN(1'b0)
  ) u_lfsr (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .load (enter_run),
    .seed (lfsr_seed),
    .step (step),
    .data ('0),
    .state(lfsr)
  );

  lbist_lfsr_misr #(
    .WIDTH  (DATA_WIDTH),
    .POLY   (LFSR_POLY),
    .DATA_EN(1'b1)
  ) u_misr (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .load (enter_run),
    .seed ('0),
    .step (step),
    .data (dut_result_i),
    .state(misr)
  );

  assign bist_active_o = step;
  assign pat_a_o       = run ? lfsr : '0;
  assign pat_b_o       = run ? {lfsr[HW-1:0], lfsr[DATA_WIDTH-1:HW]} : '0;
  assign op_sel_o      = run ? op_q : '0;
  assign error_irq_o   = fail_q & irq_en_q;

  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    unique case (1'b1)
      addr == REG_CTRL:     rdata = {29'd0, irq_en_q, auto_q, 1'b0};
      addr == REG_STATUS:   rdata = {28'd0, abort_q, fail_q, done_q, busy};
      addr == REG_GOLDEN:   rdata = 32'(golden_q);
      addr == REG_SIG:      rdata = 32'(sig_q);
      addr == REG_SEED:     rdata = 32'(seed_q);
      addr == REG_RUN_CNT:  rdata = {16'd0, run_cnt_q};
      addr == REG_FAIL_CNT: rdata = {16'd0, fail_cnt_q};
      default:              rerr  = 1'b1;
    endcase
  end

  assign apb.prdata_o  = (access & ~apb.pwrite_i) ? rdata : '0;
  assign apb.pslverr_o = access & rerr;
  assign apb.pready_o  = 1'b1;

  assign unused_apb = ^{apb.paddr_i[31:8], apb.pwdata_i};

endmodule

// File: tb/tb_alu_lbist_engine.sv
// Scoreboard bench for alu_lbist_engine with a behavioural
// run model and an in-bench ALU standing in for the wrapper.
module tb_alu_lbist_engine;

  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } rd_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } pat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idle = 1'b1;
  logic        bist_active;
  logic [31:0] pat_a;
  logic [31:0] pat_b;
  logic [1:0]  op_sel;
  logic [31:0] dut_result;
  logic        irq;

  logic        use_alu = 1'b0;
  logic        fault_en = 1'b0;
  int          fault_cyc = 0;
  logic [31:0] fault_mask = 32'h0;
  logic        pat_chk = 1'b1;
  int          rc = 0;

  int n_cmp = 0;
  int n_err = 0;

  rd_t  rd_q[$];
  pat_t pat_q[$];

  alu_lbist_engine_if bus ();

  alu_lbist_engine dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .idle_i       (idle),
    .bist_active_o(bist_active),
    .pat_a_o      (pat_a),
    .pat_b_o      (pat_b),
    .op_sel_o     (op_sel),
    .dut_result_i (dut_result),
    .apb          (bus),
    .error_irq_o  (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gstep(input logic [31:0] x);
    return (x << 1) ^ (x[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] alu_ref(input int op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      0:       return a + b;
      1:       return a ^ b;
      2:       return a << b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  // Cycle index inside the current run, used for fault injection
  always @(posedge clk) rc <= bist_active ? rc + 1 : 0;

  assign dut_result =
    (use_alu ? alu_ref(int'(op_sel), pat_a, pat_b) : 32'h0) ^
    ((fault_en && rc == fault_cyc) ? fault_mask : 32'h0);

  // Whole-run reference: 4 ops x 16 patterns, pushes the first
  // npush expected patterns and returns the final signature
  task automatic model_run(input logic [31:0] seed, input int npush,
                           output logic [31:0] sig);
    logic [31:0] x;
    logic [31:0] m;
    logic [31:0] r;
    x = (seed == 0) ? 32'd1 : seed;
    m = 32'h0;
    for (int k = 0; k < 64; k++) begin
      r = use_alu ? alu_ref(k / 16, x, swap(x)) : 32'h0;
      if (fault_en && k == fault_cyc) r = r ^ fault_mask;
      if (k < npush) pat_q.push_back('{2'(k / 16), x, swap(x)});
      m = gstep(m) ^ r;
      x = gstep(x);
    end
    sig = m;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.psel_i && bus.penable_i && !bus.pwrite_i) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %h expected none", bus.prdata_o);
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        n_cmp++;
        if (bus.prdata_o !== e.data || bus.pslverr_o !== e.err ||
            bus.pready_o !== 1'b1) begin
          n_err++;
          $display("FAIL %s: got %h err %b rdy %b expected %h err %b",
                   e.name, bus.prdata_o, bus.pslverr_o, bus.pready_o,
                   e.data, e.err);
        end
      end
    end
    if (bist_active && pat_chk) begin
      if (pat_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pat_unexpected: got %h expected none", pat_a);
      end else begin
        pat_t p;
        p = pat_q.pop_front();
        n_cmp++;
        if (pat_a !== p.a || pat_b !== p.b || op_sel !== p.op) begin
          n_err++;
          $display("FAIL pattern: got %h/%h op %0d expected %h/%h op %0d",
                   pat_a, pat_b, op_sel, p.a, p.b, p.op);
        end
      end
    end
  end

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.paddr_i  = {24'h0, a};
    bus.pwdata_i = d;
    bus.pwrite_i = 1'b1;
    bus.psel_i   = 1'b1;
    bus.penable_i = 1'b0;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    @(posedge clk); #1;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [31:0] exp,
                        input logic err, input string nm);
    rd_q.push_back('{exp, err, nm});
    @(posedge clk); #1;
    bus.paddr_i   = {24'h0, a};
    bus.pwrite_i  = 1'b0;
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    @(posedge clk); #1;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
  endtask

  task automatic wait_run(input string nm);
    int len;
    int t;
    len = 0;
    t = 0;
    while (!bist_active && t < 200) begin
      @(negedge clk);
      t++;
    end
    while (bist_active && len < 200) begin
      @(negedge clk);
      if (bist_active) len++;
    end
    check(nm, len + 1, 64);
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] sig0;
    logic [31:0] sig1;
    logic [31:0] gold;
    logic [31:0] sig3;
    logic [31:0] seed;
    int t;

    bus.paddr_i   = 32'h0;
    bus.pwdata_i  = 32'h0;
    bus.pwrite_i  = 1'b0;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_active", {31'd0, bist_active}, 0);
    check("rst_pat_a", pat_a, 0);
    check("rst_pat_b", pat_b, 0);
    check("rst_op_sel", {30'd0, op_sel}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_pready", {31'd0, bus.pready_o}, 1);
    check("rst_pslverr", {31'd0, bus.pslverr_o}, 0);
    check("rst_prdata", bus.prdata_o, 0);
    apb_rd(8'h04, 32'h0, 1'b0, "rst_status");
    apb_rd(8'h40, 32'h0, 1'b1, "unmapped");

    // zero-signature pass
    apb_wr(8'h10, 32'h0);
    apb_wr(8'h08, 32'h0);
    model_run(32'h0, 64, sig0);
    apb_wr(8'h00, 32'h5);
    wait_run("zero_len");
    apb_rd(8'h04, 32'h2, 1'b0, "zero_status");
    apb_rd(8'h0C, sig0, 1'b0, "zero_sig");
    apb_rd(8'h14, 32'd1, 1'b0, "zero_run_cnt");
    check("zero_irq", {31'd0, irq}, 0);

    // single-bit fault on run cycle 10
    fault_en = 1'b1;
    fault_cyc = 10;
    fault_mask = 32'h1;
    model_run(32'h0, 64, sig1);
    apb_wr(8'h00, 32'h5);
    wait_run("fault_len");
    apb_rd(8'h04, 32'h6, 1'b0, "fault_status");
    apb_rd(8'h0C, sig1, 1'b0, "fault_sig");
    apb_rd(8'h18, 32'd1, 1'b0, "fault_fail_cnt");
    check("fault_irq", {31'd0, irq}, 1);
    apb_wr(8'h04, 32'h4);
    check("w1c_irq", {31'd0, irq}, 0);
    apb_rd(8'h04, 32'h2, 1'b0, "w1c_status");
    fault_en = 1'b0;

    // abort on run cycle 5, then restart from SEED
    apb_wr(8'h04, 32'hE);
    use_alu = 1'b1;
    seed = $urandom | 32'h1;
    apb_wr(8'h10, seed);
    model_run(seed, 0, gold);
    apb_wr(8'h08, gold);
    model_run(seed, 5, gold);
    apb_wr(8'h00, 32'h5);
    t = 0;
    while (rc != 5 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_reach", rc, 5);
    idle = 1'b0;
    #1 check("abort_release", {31'd0, bist_active}, 0);
    repeat (3) @(posedge clk);
    apb_rd(8'h04, 32'h9, 1'b0, "abort_status");
    apb_rd(8'h0C, sig1, 1'b0, "abort_sig");
    apb_rd(8'h14, 32'd2, 1'b0, "abort_run_cnt");
    model_run(seed, 64, gold);
    idle = 1'b1;
    wait_run("restart_len");
    apb_rd(8'h04, 32'hA, 1'b0, "restart_status");
    apb_rd(8'h0C, gold, 1'b0, "restart_sig");
    apb_rd(8'h14, 32'd3, 1'b0, "restart_run_cnt");
    check("restart_irq", {31'd0, irq}, 0);

    // AUTO mode over three 70-cycle idle windows
    pat_chk = 1'b0;
    apb_wr(8'h04, 32'hE);
    idle = 1'b0;
    apb_wr(8'h00, 32'h6);
    for (int w = 0; w < 3; w++) begin
      @(posedge clk); #1 idle = 1'b1;
      repeat (70) @(posedge clk);
      #1 idle = 1'b0;
      repeat (5) @(posedge clk);
    end
    apb_rd(8'h14, 32'd6, 1'b0, "auto_run_cnt");
    apb_rd(8'h04, 32'hB, 1'b0, "auto_status");
    apb_wr(8'h00, 32'h4);
    apb_rd(8'h04, 32'hA, 1'b0, "auto_off_status");
    apb_rd(8'h18, 32'd1, 1'b0, "auto_fail_cnt");
    pat_chk = 1'b1;

    // real ALU loop with a random injected fault
    apb_wr(8'h04, 32'hE);
    idle = 1'b1;
    seed = $urandom;
    apb_wr(8'h10, seed);
    model_run(seed, 0, gold);
    apb_wr(8'h08, gold);
    fault_en = 1'b1;
    fault_cyc = int'($urandom_range(0, 63));
    fault_mask = $urandom | 32'h1;
    model_run(seed, 64, sig3);
    apb_wr(8'h00, 32'h5);
    wait_run("alu_len");
    apb_rd(8'h04, 32'h6, 1'b0, "alu_status");
    apb_rd(8'h0C, sig3, 1'b0, "alu_sig");
    apb_rd(8'h18, 32'd2, 1'b0, "alu_fail_cnt");
    apb_rd(8'h14, 32'd7, 1'b0, "alu_run_cnt");
    check("alu_irq", {31'd0, irq}, 1);

    repeat (2) @(posedge clk);
    check("pat_q_left", pat_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_lbist_engine.md
# alu_lbist_engine

Parametrised runtime logic-BIST engine for the Ibex ALU, successor to the single-pattern BIST controller. During core-sleep windows it borrows the ALU and sequences pseudo-random LFSR operand pairs across `NUM_OPS` ALU operations. It compacts every result into a MISR and compares the final signature against a software-programmed golden value. It sits between the ALU input mux in the ALU BIST wrapper and the APB peripheral bus, and raises an interrupt on mismatch.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result/signature width (≥8, even).
- `NUM_OPS`, 4: number of ALU operations exercised per run.
- `PATTERNS_PER_OP`, 16: patterns applied per operation (≥1).
- `LFSR_POLY`, 32'h8020_0003: Galois feedback polynomial, shared by LFSR and MISR.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, **asynchronous, active-low; single clock domain**.
- `idle_i`  in  1  core sleeping; ALU may be borrowed.
- `bist_active_o`  out  1  wrapper selects BIST operands/op.
- `pat_a_o`  out  DATA_WIDTH  operand A.
- `pat_b_o`  out  DATA_WIDTH  operand B.
- `op_sel_o`  out  $clog2(NUM_OPS) (min 1)  index into the package op table.
- `dut_result_i`  in  DATA_WIDTH  ALU result (combinational from the patterns).
- `paddr_i`  in  32; `psel_i`, `penable_i`, `pwrite_i`  in  1; `pwdata_i`  in  32; `prdata_o`  out  32; `pready_o`, `pslverr_o`  out  1: APB slave.
- `error_irq_o`  out  1  level interrupt.

## Operation
- Registers, decoded on `paddr_i[7:0]`:
  - 0x00 CTRL: [0] START, write-1 pulse, self-clearing. [1] AUTO, re-arm after every run. [2] IRQ_EN.
  - 0x04 STATUS: [0] BUSY (RO). [1] DONE, [2] FAIL, [3] ABORTED, all W1C.
  - 0x08 GOLDEN (RW). 0x0C SIGNATURE (RO, last completed run). 0x10 SEED (RW).
  - 0x14 RUN_CNT (RO, 16b, saturating). 0x18 FAIL_CNT (RO, 16b, saturating).
  - Other offsets: `prdata_o`=0 and `pslverr_o`=1.
- FSM states: IDLE → ARMED (START or AUTO) → RUN (when `idle_i`) → CHECK → IDLE, or ARMED again if AUTO.
- On entering RUN:
  - LFSR loads SEED; SEED=0 loads 1 to avoid lock-up.
  - MISR clears; op counter and pattern counter clear.
- Each RUN cycle:
  - `pat_a_o`=lfsr; `pat_b_o`=lfsr with upper/lower halves swapped.
  - MISR_next = shift-left(MISR) ^ (MISR[msb] ? LFSR_POLY : 0) ^ `dut_result_i`.
  - LFSR advances with the same rule, without the data input.
  - The pattern counter wraps at PATTERNS_PER_OP−1 and increments `op_sel_o`.
  - After op NUM_OPS−1 completes → CHECK.
- CHECK (1 cycle):
  - SIGNATURE←MISR; DONE←1; RUN_CNT++.
  - If MISR≠GOLDEN: FAIL←1 and FAIL_CNT++.
- Abort: `idle_i` low in RUN returns to ARMED and sets ABORTED. SIGNATURE, DONE, FAIL and the counters are unchanged. The run restarts from SEED at the next idle window.
- Writing START while BUSY is ignored. Clearing AUTO while ARMED returns to IDLE. Clearing AUTO during RUN lets the run finish.
- `error_irq_o` = FAIL & IRQ_EN.

## Timing
- Reset values:
  - All registers 0. `bist_active_o`=0. Patterns 0. `op_sel_o`=0.
  - `prdata_o`=0. `pready_o`=1. `pslverr_o`=0. `error_irq_o`=0. FSM in IDLE.
- `bist_active_o` = (state==RUN) & `idle_i`, combinational, so the ALU is released in the same cycle `idle_i` falls.
- One pattern per cycle. A full run takes NUM_OPS·PATTERNS_PER_OP RUN cycles plus 1 CHECK cycle. The ARMED→RUN transition is 1 cycle after `idle_i` is seen high.
- APB:
  - Zero wait states; `pready_o` is held at 1.
  - Writes commit on the clock edge of the access phase (`psel_i`&`penable_i`).
  - Read data is combinational during the access phase.
- A W1C to FAIL in the same cycle as a CHECK that sets FAIL: the set wins.
- Counters hold at 16'hFFFF.

## Structure
- Shared package `alu_lbist_pkg` holds:
  - The register offset constants.
  - The FSM state enum.
  - The `NUM_OPS` → `alu_op_e` table: ADD, XOR, SLL, SLT by default.
- One sub-module, `lbist_lfsr_misr`, parametrised by width, polynomial and data-input enable. It is instanced twice: once as the LFSR, once as the MISR.
- The APB register block is in-module.

## Test plan
- Reset check: release reset → all outputs at their reset values; STATUS reads 0x0; unmapped address 0x40 → `pslverr_o`=1, `prdata_o`=0.
- Zero-signature pass:
  - Setup: SEED=0, GOLDEN=0, `dut_result_i` tied to 0, START with IRQ_EN set, `idle_i`=1.
  - Sequence: BUSY for 64 cycles; `pat_a_o` starts at 0x0000_0001; `op_sel_o` steps 0→3 every 16 cycles.
  - Result: STATUS=0x2 (DONE), SIGNATURE=0, `error_irq_o`=0, RUN_CNT=1.
- Injected fault:
  - Setup: as the pass case, but `dut_result_i`=0x1 on RUN cycle 10 only.
  - Result: FAIL=1, SIGNATURE≠0 and matching the reference model, `error_irq_o`=1.
  - Follow-up: W1C of 0x4 to STATUS drops `error_irq_o` the next cycle.
- Abort: drop `idle_i` on RUN cycle 5 → `bist_active_o`=0 in the same cycle; ABORTED=1; SIGNATURE and RUN_CNT unchanged. Raising `idle_i` again restarts from SEED, and the run completes with DONE.
- AUTO mode: CTRL=0x6 with three idle windows of 70 cycles → RUN_CNT=3, and the FSM re-arms after each CHECK.
- Real ALU loop: connect the ALU BIST wrapper, program GOLDEN from a golden-model run, and run → FAIL=0. Forcing the ALU fault-injection input → FAIL=1 and FAIL_CNT=1.
